count_seq_checker: RTL and testbench
====================================

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter WIDTH, default 4, is the width of the observed count.
REQ-002 Parameter SYNC_LEN, default 3, is the number of consecutive correct increments needed to lock.
REQ-003 Parameter CNT_W, default 8, is the width of the error and wrap statistics counters.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  sample-valid; count_in is examined only on rising edges where en=1.
REQ-007 count_in  input  WIDTH  observed up-counter value.
REQ-008 synced  output  1  level; high while in LOCKED.
REQ-009 error  output  1  one-cycle pulse on a sequence violation while locked.
REQ-010 restart  output  1  one-cycle pulse when a locked stream jumps to 0 early (upstream reset).
REQ-011 wrap  output  1  one-cycle pulse on a locked 2^WIDTH-1 -> 0 transition.
REQ-012 err_cnt  output  CNT_W  saturating count of error pulses.
REQ-013 wrap_cnt  output  CNT_W  saturating count of wrap pulses.

Function
REQ-014 The block SHALL keep a registered prev sample and define expected = (prev + 1) mod 2^WIDTH.
REQ-015 The FSM SHALL have exactly three states: IDLE, ACQUIRE and LOCKED.
REQ-016 IDLE: the first en sample SHALL be captured into prev, clear match_cnt, and go to ACQUIRE.
REQ-017 ACQUIRE, en and count_in == expected: match_cnt SHALL increment; on reaching SYNC_LEN the FSM SHALL go to LOCKED.
REQ-018 ACQUIRE, en and count_in != expected: match_cnt SHALL clear and the FSM SHALL stay in ACQUIRE, with no error pulse.
REQ-019 LOCKED, en and count_in == expected: the FSM SHALL stay in LOCKED; if prev == 2^WIDTH-1, wrap SHALL pulse and wrap_cnt SHALL increment.
REQ-020 LOCKED, en, count_in == 0 and expected != 0: restart SHALL pulse with no error, match_cnt SHALL clear, and the FSM SHALL go to ACQUIRE.
REQ-021 LOCKED, en, any other count_in != expected (including hold, count_in == prev): error SHALL pulse, err_cnt SHALL increment, match_cnt SHALL clear, and the FSM SHALL go to ACQUIRE.
REQ-022 On every en cycle outside IDLE, prev SHALL load count_in, whatever the compare result.
REQ-023 When en=0, state, prev, match_cnt and counters SHALL hold, and the pulse outputs SHALL be 0.
REQ-024 All outputs SHALL be registered; a pulse SHALL be high during the cycle after the sampling edge, for exactly one cycle.
REQ-025 synced SHALL rise in the cycle after the locking sample and fall in the cycle after the violating or restart sample.
REQ-026 err_cnt and wrap_cnt SHALL saturate at 2^CNT_W-1; pulses SHALL still fire while saturated.
REQ-027 error, restart and wrap SHALL be mutually exclusive in any cycle.

Reset
REQ-028 resetN low SHALL immediately force: state IDLE, prev 0, match_cnt 0, synced 0, error 0, restart 0, wrap 0, err_cnt 0, wrap_cnt 0.
REQ-029 Reset asserted mid-lock SHALL discard all history; after release, the next en sample SHALL be treated as the first (IDLE path).
REQ-030 Reset release SHALL be synchronised to clk internally so the first en sample after release is never half-applied.

Verification
REQ-031 en=1, count_in 0,1,2,3 -> synced rises the cycle after the sample 3; error, restart and err_cnt stay 0.
REQ-032 Locked, count_in ...14,15,0,1 (WIDTH=4) -> one wrap pulse the cycle after the sample 0; wrap_cnt=1; synced stays 1.
REQ-033 Locked, count_in 5,6,9 -> error pulse after the sample 9; err_cnt=1; synced=0; then 10,11,12 -> synced=1 again.
REQ-034 Locked at 7, upstream counter reset gives count_in 0 -> restart pulse only, err_cnt unchanged; relock after 1,2,3.
REQ-035 Locked, en toggled 1,0,0,1 with count_in 4 held during gaps then 5 -> no error; state and outputs hold during en=0.
REQ-036 CNT_W=2, inject 5 violations -> err_cnt saturates at 3; all 5 error pulses observed; resetN pulsed low mid-run -> every output is 0 at once.

Source files
------------

// File: rtl/count_seq_checker.sv
// count_seq_checker: watches a free-running up-counter and locks once it sees
// a run of clean increments. While locked it reports sequence violations,
// early jumps to zero (upstream restarts) and natural wrap-arounds.
// It also keeps saturating statistics for errors and wraps.
`timescale 1ns/1ps

module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int SYNC_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  output logic             synced,
  output logic             error,
  output logic             restart,
  output logic             wrap,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
);

  localparam int                 MATCH_W      = $clog2(SYNC_LEN + 1);
  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(SYNC_LEN);
  localparam logic [WIDTH-1:0]   COUNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   STAT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Internal reset: asserts together with resetN, releases two clk edges later.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   prev_q,     prev_d;
  logic [MATCH_W-1:0] match_q,    match_d;
  logic               synced_q,   synced_d;
  logic               error_q,    error_d;
  logic               restart_q,  restart_d;
  logic               wrap_q,     wrap_d;
  logic [CNT_W-1:0]   err_cnt_q,  err_cnt_d;
  logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;

  logic [WIDTH-1:0]   expected;
  logic [MATCH_W-1:0] match_inc;

  // Shift ones into the reset synchroniser once resetN is released.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser: asynchronous assert, clk-aligned release.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Next-state, compare and statistics logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    match_d    = match_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    error_d    = 1'b0;
    restart_d  = 1'b0;
    wrap_d     = 1'b0;
    expected   = prev_q + WIDTH'(1);
    match_inc  = match_q + MATCH_W'(1);

    if (en) begin
      prev_d = count_in;
      unique case (state_q)
        IDLE: begin
          match_d = '0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (count_in == expected) begin
            match_d = match_inc;
            if (match_inc == MATCH_TARGET) begin
              state_d = LOCKED;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (count_in == expected) begin
            if (prev_q == COUNT_MAX) begin
              wrap_d = 1'b1;
              if (wrap_cnt_q != STAT_MAX) begin
                wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
              end
            end
          end else begin
            match_d = '0;
            state_d = ACQUIRE;
            if (count_in == '0) begin
              restart_d = 1'b1;
            end else begin
              error_d = 1'b1;
              if (err_cnt_q != STAT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    synced_d = (state_d == LOCKED);
  end

  // State and registered outputs, cleared by the synchronised reset.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      match_q    <= '0;
      synced_q   <= 1'b0;
      error_q    <= 1'b0;
      restart_q  <= 1'b0;
      wrap_q     <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      synced_q   <= synced_d;
      error_q    <= error_d;
      restart_q  <= restart_d;
      wrap_q     <= wrap_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign synced   = synced_q;
  assign error    = error_q;
  assign restart  = restart_q;
  assign wrap     = wrap_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;

  // The three event pulses never fire together.
  a_pulse_exclusive : assert property (@(posedge clk) disable iff (!rst_int_n)
    $onehot0({error_q, restart_q, wrap_q}));

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed stimulus against count_seq_checker with a
// sample-level reference model checked every cycle plus literal checkpoints.
`timescale 1ns/1ps

module tb_count_seq_checker;

  localparam int WIDTH    = 4;
  localparam int SYNC_LEN = 3;
  localparam int CNT_W    = 2;
  localparam int MOD      = 1 << WIDTH;
  localparam int STAT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             resetN = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             synced;
  logic             error;
  logic             restart;
  logic             wrap;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] wrap_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: sample history reduced to the last value and run length.
  bit m_started;
  bit m_locked;
  int m_prev;
  int m_run;
  int m_errs;
  int m_wraps;
  int rst_age;
  bit exp_err;
  bit exp_rst;
  bit exp_wrap;
  int npulse;
  int err_pulses_seen  = 0;
  int wrap_pulses_seen = 0;

  count_seq_checker #(
    .WIDTH   (WIDTH),
    .SYNC_LEN(SYNC_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .resetN  (resetN),
    .en      (en),
    .count_in(count_in),
    .synced  (synced),
    .error   (error),
    .restart (restart),
    .wrap    (wrap),
    .err_cnt (err_cnt),
    .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_clear();
    m_started = 0;
    m_locked  = 0;
    m_prev    = 0;
    m_run     = 0;
    m_errs    = 0;
    m_wraps   = 0;
    exp_err   = 0;
    exp_rst   = 0;
    exp_wrap  = 0;
  endfunction

  function automatic void model_step(input bit e, input int cin);
    int nxt;
    exp_err  = 0;
    exp_rst  = 0;
    exp_wrap = 0;
    if (!e) return;
    if (!m_started) begin
      m_started = 1;
      m_prev    = cin;
      m_run     = 0;
      return;
    end
    nxt = (m_prev + 1) % MOD;
    if (m_locked) begin
      if (cin == nxt) begin
        if (m_prev == MOD - 1) begin
          exp_wrap = 1;
          m_wraps++;
        end
      end else begin
        m_locked = 0;
        m_run    = 0;
        if (cin == 0) begin
          exp_rst = 1;
        end else begin
          exp_err = 1;
          m_errs++;
        end
      end
    end else if (cin == nxt) begin
      m_run++;
      if (m_run >= SYNC_LEN) m_locked = 1;
    end else begin
      m_run = 0;
    end
    m_prev = cin;
  endfunction

  // Advance the model on each edge, then compare every DUT output just after it.
  always @(posedge clk) begin
    if (!resetN) begin
      model_clear();
      rst_age = 0;
    end else if (rst_age >= 2) begin
      model_step(en, int'(count_in));
    end else begin
      exp_err  = 0;
      exp_rst  = 0;
      exp_wrap = 0;
      rst_age++;
    end
    #1;
    check_output("synced",   synced,   m_locked);
    check_output("error",    error,    exp_err);
    check_output("restart",  restart,  exp_rst);
    check_output("wrap",     wrap,     exp_wrap);
    check_output("err_cnt",  err_cnt,  (m_errs  > STAT_MAX) ? STAT_MAX : m_errs);
    check_output("wrap_cnt", wrap_cnt, (m_wraps > STAT_MAX) ? STAT_MAX : m_wraps);
    npulse = int'(error) + int'(restart) + int'(wrap);
    check_output("pulse_excl", npulse <= 1, 1);
    if (error) err_pulses_seen++;
    if (wrap)  wrap_pulses_seen++;
  end

  task automatic apply_stimulus(input logic e, input int v);
    @(negedge clk);
    en       = e;
    count_in = WIDTH'(v);
    @(posedge clk);
    #2;
  endtask

  task automatic send_run(input int from, input int to);
    for (int v = from; v <= to; v++) apply_stimulus(1'b1, v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 resetN = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_output("rst_synced",   synced,   0);
    check_output("rst_error",    error,    0);
    check_output("rst_err_cnt",  err_cnt,  0);
    check_output("rst_wrap_cnt", wrap_cnt, 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) apply_stimulus(1'b0, 0);

    // Acquire lock on 0,1,2,3
    send_run(0, 2);
    check_output("lock_early", synced, 0);
    apply_stimulus(1'b1, 3);
    check_output("lock_synced",  synced,  1);
    check_output("lock_error",   error,   0);
    check_output("lock_restart", restart, 0);
    check_output("lock_err_cnt", err_cnt, 0);

    // Natural wrap 15 -> 0
    send_run(4, 15);
    apply_stimulus(1'b1, 0);
    check_output("wrap1_pulse",  wrap,     1);
    check_output("wrap1_cnt",    wrap_cnt, 1);
    check_output("wrap1_synced", synced,   1);
    apply_stimulus(1'b1, 1);
    check_output("wrap1_end", wrap, 0);

    // en gaps with the value held
    send_run(2, 4);
    apply_stimulus(1'b0, 4);
    check_output("gap_synced", synced, 1);
    check_output("gap_error",  error,  0);
    apply_stimulus(1'b0, 4);
    apply_stimulus(1'b1, 5);
    check_output("gap_after_error",  error,  0);
    check_output("gap_after_synced", synced, 1);

    // Violation 6 -> 9, then relock on 10,11,12
    apply_stimulus(1'b1, 6);
    apply_stimulus(1'b1, 9);
    check_output("viol_error",   error,   1);
    check_output("viol_err_cnt", err_cnt, 1);
    check_output("viol_synced",  synced,  0);
    send_run(10, 11);
    check_output("relock_early", synced, 0);
    apply_stimulus(1'b1, 12);
    check_output("relock_synced", synced, 1);

    // Upstream restart at 7 -> 0
    send_run(13, 15);
    apply_stimulus(1'b1, 0);
    check_output("wrap2_cnt", wrap_cnt, 2);
    send_run(1, 7);
    apply_stimulus(1'b1, 0);
    check_output("restart_pulse",   restart, 1);
    check_output("restart_error",   error,   0);
    check_output("restart_err_cnt", err_cnt, 1);
    check_output("restart_synced",  synced,  0);
    send_run(1, 3);
    check_output("restart_relock", synced, 1);

    // Error counter saturation at 3 with five violations in total
    apply_stimulus(1'b1, 3);
    check_output("hold_error",   error,   1);
    check_output("hold_err_cnt", err_cnt, 2);
    send_run(4, 6);
    apply_stimulus(1'b1, 9);
    check_output("sat3_err_cnt", err_cnt, 3);
    send_run(10, 12);
    apply_stimulus(1'b1, 12);
    check_output("sat4_error",   error,   1);
    check_output("sat4_err_cnt", err_cnt, 3);
    send_run(13, 15);
    apply_stimulus(1'b1, 2);
    check_output("sat5_error",   error,   1);
    check_output("sat5_err_cnt", err_cnt, 3);
    check_output("err_pulses",   err_pulses_seen, 5);

    // Wrap counter saturation
    send_run(3, 15);
    apply_stimulus(1'b1, 0);
    check_output("wrap3_cnt", wrap_cnt, 3);
    send_run(1, 15);
    apply_stimulus(1'b1, 0);
    check_output("wrap4_pulse", wrap,     1);
    check_output("wrap4_cnt",   wrap_cnt, 3);
    check_output("wrap_pulses", wrap_pulses_seen, 4);

    // Asynchronous reset mid-lock clears every output at once
    apply_stimulus(1'b1, 1);
    @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    check_output("async_synced",   synced,   0);
    check_output("async_error",    error,    0);
    check_output("async_restart",  restart,  0);
    check_output("async_wrap",     wrap,     0);
    check_output("async_err_cnt",  err_cnt,  0);
    check_output("async_wrap_cnt", wrap_cnt, 0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) apply_stimulus(1'b0, 0);

    // History discarded: 5 is a first sample, lock only after 6,7,8
    send_run(5, 7);
    check_output("post_rst_early", synced, 0);
    apply_stimulus(1'b1, 8);
    check_output("post_rst_synced",  synced,  1);
    check_output("post_rst_err_cnt", err_cnt, 0);

    apply_stimulus(1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
